// File: rtl/dma_cnt_pkg.sv
// Shared constants, types and helpers for the DMA per-channel address/word-count engine.
// Register-select encoding follows the 8237 I/O map: even = address, odd = word count.
package dma_cnt_pkg;

  localparam int CH_NUM = 4;
  localparam int AW     = 16;

  typedef logic [1:0] chIdx_t;

  typedef enum logic [2:0] {
    CH0_ADDR = 3'd0,
    CH0_WC   = 3'd1,
    CH1_ADDR = 3'd2,
    CH1_WC   = 3'd3,
    CH2_ADDR = 3'd4,
    CH2_WC   = 3'd5,
    CH3_ADDR = 3'd6,
    CH3_WC   = 3'd7
  } regSel_t;

  typedef struct packed {
    logic [AW-1:0] baseAddr;
    logic [AW-1:0] curAddr;
    logic [AW-1:0] baseWc;
    logic [AW-1:0] curWc;
  } chanRegs_t;

  // Replace one byte of a register, leaving the other byte untouched.
  function automatic logic [AW-1:0] set_byte(input logic [AW-1:0] val,
                                             input logic          hi,
                                             input logic [7:0]    b);
    logic [AW-1:0] r;
    r = val;
    if (hi) r[15:8] = b;
    else    r[7:0]  = b;
    return r;
  endfunction

endpackage

// File: rtl/dma_chan_regs.sv
// One channel's base/current address and word-count registers with byte load, step and TC detect.
// tc_hit is combinational: it flags that the step applied at the next edge is the terminal one.
module dma_chan_regs
  import dma_cnt_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       wr_en,
  input  logic       wr_wc,
  input  logic       wr_hi,
  input  logic [7:0] wr_byte,
  input  logic       step_en,
  input  logic       dec,
  input  logic       autoinit,
  output chanRegs_t  regs,
  output logic       tc_hit
);

  logic wc_zero;

  assign wc_zero = (regs.curWc == '0);
  assign tc_hit  = step_en & wc_zero;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs <= '0;
    end else if (wr_en) begin
      if (wr_wc) begin
        regs.baseWc <= set_byte(regs.baseWc, wr_hi, wr_byte);
        regs.curWc  <= set_byte(regs.curWc, wr_hi, wr_byte);
      end else begin
        regs.baseAddr <= set_byte(regs.baseAddr, wr_hi, wr_byte);
        regs.curAddr  <= set_byte(regs.curAddr, wr_hi, wr_byte);
      end
    end else if (step_en) begin
      if (wc_zero && autoinit) begin
        regs.curAddr <= regs.baseAddr;
        regs.curWc   <= regs.baseWc;
      end else begin
        // A zero count without autoinit wraps to all-ones by plain decrement.
        regs.curWc   <= regs.curWc - 1'b1;
        regs.curAddr <= dec ? regs.curAddr - 1'b1 : regs.curAddr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_channel_counter.sv
// 8237-style per-channel address/word-count engine: byte-pointer programming, read mux, step and TC.
// Optional sticky per-channel TC status bits when DMA_TC_STATUS_EN is defined.
module dma_channel_counter #(
  parameter int CH_NUM = dma_cnt_pkg::CH_NUM,
  parameter int AW     = dma_cnt_pkg::AW
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              prog_we,
  input  logic              prog_re,
  input  logic [2:0]        prog_addr,
  input  logic [7:0]        prog_din,
  output logic [7:0]        prog_dout,
  input  logic              clear_ff,
  input  logic [1:0]        active_ch,
  input  logic              step,
  input  logic [CH_NUM-1:0] mode_dec,
  input  logic [CH_NUM-1:0] mode_autoinit,
  output logic [AW-1:0]     cur_addr,
  output logic              tc,
  output logic [1:0]        tc_ch,
  output logic              ff_state
`ifdef DMA_TC_STATUS_EN
  ,
  input  logic              status_rd,
  output logic [CH_NUM-1:0] tc_status
`endif
);

  import dma_cnt_pkg::chanRegs_t;
  import dma_cnt_pkg::chIdx_t;
  import dma_cnt_pkg::regSel_t;
  import dma_cnt_pkg::CH0_WC;
  import dma_cnt_pkg::CH1_WC;
  import dma_cnt_pkg::CH2_WC;
  import dma_cnt_pkg::CH3_WC;

  regSel_t           sel;
  chIdx_t            sel_ch;
  logic              sel_wc;
  logic              ff_eff;
  logic [AW-1:0]     rd_word;
  chanRegs_t         regs [CH_NUM];
  logic [CH_NUM-1:0] tc_hit;

  assign sel    = regSel_t'(prog_addr);
  assign sel_ch = chIdx_t'(prog_addr[2:1]);
  assign sel_wc = (sel inside {CH0_WC, CH1_WC, CH2_WC, CH3_WC});
  // clear_ff takes effect before a same-cycle access picks its byte.
  assign ff_eff = ff_state & ~clear_ff;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic wr_this;
    logic step_this;

    assign wr_this   = prog_we && (sel_ch == 2'(c));
    assign step_this = step && (active_ch == 2'(c)) && !wr_this;

    dma_chan_regs u_regs (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .wr_en    (wr_this),
      .wr_wc    (sel_wc),
      .wr_hi    (ff_eff),
      .wr_byte  (prog_din),
      .step_en  (step_this),
      .dec      (mode_dec[c]),
      .autoinit (mode_autoinit[c]),
      .regs     (regs[c]),
      .tc_hit   (tc_hit[c])
    );
  end

  assign rd_word  = sel_wc ? regs[sel_ch].curWc : regs[sel_ch].curAddr;
  assign cur_addr = regs[active_ch].curAddr;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ff_state  <= 1'b0;
      prog_dout <= 8'h00;
    end else begin
      if (prog_we || prog_re) ff_state <= ~ff_eff;
      else                    ff_state <= ff_eff;
      if (prog_re && !prog_we) prog_dout <= ff_eff ? rd_word[15:8] : rd_word[7:0];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tc    <= 1'b0;
      tc_ch <= 2'd0;
    end else begin
      tc <= |tc_hit;
      if (|tc_hit) tc_ch <= active_ch;
    end
  end

`ifdef DMA_TC_STATUS_EN
  // A terminal count landing on the same edge as the clear survives it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) tc_status <= '0;
    else          tc_status <= (status_rd ? '0 : tc_status) | tc_hit;
  end
`endif

endmodule

// File: tb/tb_dma_channel_counter.sv
// Directed bench for dma_channel_counter: arithmetic reference model checked every cycle
// plus hand-computed expectations taken from the documented scenarios.
module tb_dma_channel_counter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        prog_we, prog_re, clear_ff, step;
  logic [2:0]  prog_addr;
  logic [7:0]  prog_din;
  logic [7:0]  prog_dout;
  logic [1:0]  active_ch;
  logic [3:0]  mode_dec, mode_autoinit;
  logic [15:0] cur_addr;
  logic        tc;
  logic [1:0]  tc_ch;
  logic        ff_state;
`ifdef DMA_TC_STATUS_EN
  logic        status_rd;
  logic [3:0]  tc_status;
`endif

  int checks   = 0;
  int failures = 0;

  dma_channel_counter dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .prog_we       (prog_we),
    .prog_re       (prog_re),
    .prog_addr     (prog_addr),
    .prog_din      (prog_din),
    .prog_dout     (prog_dout),
    .clear_ff      (clear_ff),
    .active_ch     (active_ch),
    .step          (step),
    .mode_dec      (mode_dec),
    .mode_autoinit (mode_autoinit),
    .cur_addr      (cur_addr),
    .tc            (tc),
    .tc_ch         (tc_ch),
    .ff_state      (ff_state)
`ifdef DMA_TC_STATUS_EN
    ,
    .status_rd     (status_rd),
    .tc_status     (tc_status)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic over per-channel arrays.
  int unsigned m_ba[4], m_ca[4], m_bw[4], m_cw[4];
  int unsigned m_dout, m_tc, m_tc_ch, m_ff, m_status;

  function automatic int unsigned put_byte(int unsigned old, int unsigned hi, int unsigned d);
    return hi ? ((old % 256) + d * 256) : ((old / 256) * 256 + d);
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    int unsigned f, c, a, word, fired;
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) begin
        m_ba[i] = 0; m_ca[i] = 0; m_bw[i] = 0; m_cw[i] = 0;
      end
      m_dout = 0; m_tc = 0; m_tc_ch = 0; m_ff = 0; m_status = 0;
    end else begin
      f = clear_ff ? 0 : m_ff;
      c = prog_addr / 2;
      a = active_ch;
      fired = 0;
      if (prog_re && !prog_we) begin
        word = prog_addr[0] ? m_cw[c] : m_ca[c];
        m_dout = f ? word / 256 : word % 256;
      end
      if (step && !(prog_we && c == a)) begin
        if (m_cw[a] == 0) begin
          fired = 1;
          if (mode_autoinit[a]) begin
            m_ca[a] = m_ba[a];
            m_cw[a] = m_bw[a];
          end else begin
            m_cw[a] = 65535;
            m_ca[a] = mode_dec[a] ? (m_ca[a] + 65535) % 65536 : (m_ca[a] + 1) % 65536;
          end
        end else begin
          m_cw[a] = m_cw[a] - 1;
          m_ca[a] = mode_dec[a] ? (m_ca[a] + 65535) % 65536 : (m_ca[a] + 1) % 65536;
        end
      end
      if (prog_we) begin
        if (prog_addr[0]) begin
          m_bw[c] = put_byte(m_bw[c], f, prog_din);
          m_cw[c] = put_byte(m_cw[c], f, prog_din);
        end else begin
          m_ba[c] = put_byte(m_ba[c], f, prog_din);
          m_ca[c] = put_byte(m_ca[c], f, prog_din);
        end
      end
      m_ff = (prog_we || prog_re) ? 1 - f : f;
      m_tc = fired;
      if (fired) m_tc_ch = a;
`ifdef DMA_TC_STATUS_EN
      m_status = (status_rd ? 0 : m_status) | (fired << a);
`endif
    end
  end

  always @(negedge CLK) begin
    chk("model_cur_addr", cur_addr, m_ca[active_ch]);
    chk("model_tc", tc, m_tc);
    chk("model_tc_ch", tc_ch, m_tc_ch);
    chk("model_ff", ff_state, m_ff);
    chk("model_dout", prog_dout, m_dout);
`ifdef DMA_TC_STATUS_EN
    chk("model_status", tc_status, m_status);
`endif
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_din = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    prog_re = 1'b1; prog_addr = a;
    tick();
    prog_re = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0;
    prog_we = 0; prog_re = 0; clear_ff = 0; step = 0;
    prog_addr = 0; prog_din = 0; active_ch = 0;
    mode_dec = 4'b0100; mode_autoinit = 4'b1000;
`ifdef DMA_TC_STATUS_EN
    status_rd = 0;
`endif
    tick(); tick();
    RESET_N = 1'b1;
    tick();
    chk("rst_tc", tc, 0);
    chk("rst_tc_ch", tc_ch, 0);
    chk("rst_ff", ff_state, 0);
    chk("rst_dout", prog_dout, 8'h00);
    chk("rst_addr", cur_addr, 16'h0000);

    // ch0 address programmed byte by byte, then read back
    wr(3'd0, 8'h34);
    chk("ff_after_low", ff_state, 1);
    wr(3'd0, 8'h12);
    chk("ff_after_high", ff_state, 0);
    chk("ch0_addr", cur_addr, 16'h1234);
    rd(3'd0);
    chk("rd_low", prog_dout, 8'h34);
    rd(3'd0);
    chk("rd_high", prog_dout, 8'h12);

    // ch1 increment, wc=2 -> three transfers, tc on the third
    wr(3'd3, 8'h02); wr(3'd3, 8'h00);
    wr(3'd2, 8'h00); wr(3'd2, 8'h01);
    active_ch = 2'd1; step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ch1_tc_seq", tc, (i == 2) ? 1 : 0);
    end
    step = 1'b0;
    chk("ch1_tc_ch", tc_ch, 2'd1);
    chk("ch1_addr", cur_addr, 16'h0103);
    tick();
    chk("ch1_tc_one_cycle", tc, 0);
    rd(3'd3);
    chk("ch1_wc_lo", prog_dout, 8'hFF);
    rd(3'd3);
    chk("ch1_wc_hi", prog_dout, 8'hFF);

    // ch2 decrement wraps below zero
    wr(3'd4, 8'h00); wr(3'd4, 8'h00);
    wr(3'd5, 8'h05); wr(3'd5, 8'h00);
    active_ch = 2'd2; step = 1'b1;
    tick();
    step = 1'b0;
    chk("ch2_addr_wrap", cur_addr, 16'hFFFF);
    chk("ch2_no_tc", tc, 0);
    rd(3'd5);
    chk("ch2_wc", prog_dout, 8'h04);

    // ch2 wc high byte, then ch3 autoinit restores base values
    rd(3'd5);
    wr(3'd6, 8'h00); wr(3'd6, 8'h40);
    wr(3'd7, 8'h01); wr(3'd7, 8'h00);
    active_ch = 2'd3; step = 1'b1;
    tick();
    chk("ch3_first_step", cur_addr, 16'h4001);
    chk("ch3_no_tc_yet", tc, 0);
    tick();
    step = 1'b0;
    chk("ch3_tc", tc, 1);
    chk("ch3_tc_ch", tc_ch, 2'd3);
    chk("ch3_addr_restored", cur_addr, 16'h4000);
    rd(3'd7);
    chk("ch3_wc_restored", prog_dout, 8'h01);
    rd(3'd7);

    // byte-pointer clear, alone and together with an access
    wr(3'd3, 8'h55);
    chk("ff_low_only", ff_state, 1);
    clear_ff = 1'b1; tick(); clear_ff = 1'b0;
    chk("ff_cleared", ff_state, 0);
    wr(3'd3, 8'h77);
    clear_ff = 1'b1; wr(3'd3, 8'hAA); clear_ff = 1'b0;
    chk("ff_clear_write", ff_state, 1);
    clear_ff = 1'b1; rd(3'd3); clear_ff = 1'b0;
    chk("ch1_wc_lo_AA", prog_dout, 8'hAA);
    chk("ff_clear_read", ff_state, 1);
    rd(3'd3);
    chk("ch1_wc_hi_kept", prog_dout, 8'hFF);

    // program write to ch0 beats a step on ch0 whose wc is zero
    active_ch = 2'd0; step = 1'b1;
    wr(3'd0, 8'h99);
    step = 1'b0;
    chk("wr_beats_step_tc", tc, 0);
    chk("wr_beats_step_addr", cur_addr, 16'h1299);

    // simultaneous write and read: write only, single toggle
    prog_re = 1'b1; wr(3'd0, 8'h56); prog_re = 1'b0;
    chk("we_re_dout_held", prog_dout, 8'hFF);
    chk("we_re_ff", ff_state, 0);
    chk("we_re_addr", cur_addr, 16'h5699);

    // step on ch1 while ch2 is programmed proceeds
    active_ch = 2'd1; step = 1'b1;
    wr(3'd4, 8'h11);
    step = 1'b0;
    chk("other_ch_step", cur_addr, 16'h0104);

`ifdef DMA_TC_STATUS_EN
    clear_ff = 1'b1; tick(); clear_ff = 1'b0;
    wr(3'd3, 8'h00); wr(3'd3, 8'h00);
    active_ch = 2'd1; step = 1'b1; tick(); step = 1'b0;
    chk("status_set_ch1", tc_status, 4'b0010);
    status_rd = 1'b1; tick(); status_rd = 1'b0;
    chk("status_cleared", tc_status, 4'b0000);
    clear_ff = 1'b1; tick(); clear_ff = 1'b0;
    wr(3'd1, 8'h00); wr(3'd1, 8'h00);
    active_ch = 2'd0; step = 1'b1; status_rd = 1'b1;
    tick();
    step = 1'b0; status_rd = 1'b0;
    chk("status_set_beats_clear", tc_status, 4'b0001);
`endif

    // asynchronous reset with a terminal count due on the next edge
    clear_ff = 1'b1; tick(); clear_ff = 1'b0;
    wr(3'd1, 8'h00); wr(3'd1, 8'h00);
    active_ch = 2'd0; step = 1'b1;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rst_addr", cur_addr, 16'h0000);
    chk("async_rst_ff", ff_state, 0);
    tick();
    chk("async_rst_tc_lost", tc, 0);
    step = 1'b0;
    RESET_N = 1'b1;
    tick();
    chk("post_rst_tc", tc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_channel_counter.md
Name: dma_channel_counter

Overview:
- Per-channel address/word-count engine of the 8237-style DMA controller; sits downstream of the priority logic and timing control.
- Holds base and current address and word-count registers for 4 channels, all CPU-programmable over the 8-bit I/O port through a byte-pointer flip-flop.
- Steps the active channel's registers once per transfer cycle.
- Drives the 16-bit transfer address and the terminal-count (TC) pulse back to timing control and EOP logic.

Parameters:
- CH_NUM, 4, number of channels; channel index width is $clog2(CH_NUM).
- AW, 16, address and word-count register width.

Ports:
- CLK  input  1  system clock.
- RESET_N  input  1  asynchronous active-low reset.
- prog_we  input  1  I/O write strobe, one cycle, already qualified by CS_N/IOW_N decode.
- prog_re  input  1  I/O read strobe, one cycle, qualified.
- prog_addr  input  3  register select: even = channel addr, odd = channel word count, channel = prog_addr[2:1].
- prog_din  input  8  write data byte.
- prog_dout  output  8  registered read data byte.
- clear_ff  input  1  clear byte-pointer flip-flop (software command or master clear).
- active_ch  input  2  channel being serviced (from priority logic).
- step  input  1  one-cycle pulse from timing control (S4) to advance active_ch.
- mode_dec  input  CH_NUM  per channel: 1 = address decrement, 0 = increment.
- mode_autoinit  input  CH_NUM  per channel: autoinitialize enable.
- cur_addr  output  AW  current address of active_ch (combinational mux of registers).
- tc  output  1  terminal-count pulse.
- tc_ch  output  2  channel that produced tc.
- ff_state  output  1  byte-pointer state (0 = low byte next).

Behaviour:
- Reset (RESET_N low, asynchronous): all base/current regs = 0, ff_state = 0, prog_dout = 8'h00, tc = 0, tc_ch = 0.
- Write, prog_we=1:
  - byte = ff_state ? high : low; written into both the base and current register selected by prog_addr.
  - ff_state toggles.
  - Registers are visible next cycle.
- Read, prog_re=1:
  - prog_dout at the next edge = selected byte of the *current* register; holds until the next read.
  - ff_state toggles.
- prog_we and prog_re in the same cycle: the write is performed, the read is ignored, ff toggles once.
- clear_ff:
  - Forces ff_state = 0 before any same-cycle access is evaluated. That access therefore uses the low byte and leaves ff_state = 1.
  - Alone, it leaves ff_state = 0.
- Step, step=1 for channel c = active_ch (all updates at the next edge, latency 1):
  - wc_cur == 0: tc = 1 and tc_ch = c for exactly one cycle.
    - autoinit=1: cur addr ← base addr, cur wc ← base wc.
    - autoinit=0: cur wc wraps to 16'hFFFF and the address advances normally.
  - wc_cur != 0: wc_cur - 1; addr ± 1 mod 2^AW (16'hFFFF+1 → 0, 0-1 → 16'hFFFF); tc = 0.
- Program and step to the same channel in the same cycle: the program write wins, the step is dropped for that channel, tc stays 0. A step to a different channel proceeds normally.
- Word count N therefore yields N+1 transfers before tc.
- Only one channel is stepped per cycle; registers of all other channels hold.
- A reset mid-transfer clears everything immediately. A tc pending for the next edge is lost.

Optional Feature:
- Macro DMA_TC_STATUS_EN.
- Defined:
  - Adds output tc_status [CH_NUM-1:0] and input status_rd (1).
  - Bit c is set on the edge at which tc fires for channel c.
  - All bits clear on the edge after status_rd=1; a same-cycle set wins over the clear.
  - Reset value 0. This feeds status register bits [3:0].
- Undefined: neither port exists and there are no sticky bits.

Decomposition:
- Package dma_cnt_pkg:
  - CH_NUM and AW constants.
  - chIdx_t (2-bit).
  - regSel_t enum {CH0_ADDR..CH3_WC} (8 entries).
  - Struct chanRegs_t {baseAddr, curAddr, baseWc, curWc}.
- Sub-module dma_chan_regs: one channel's four registers plus load, step and TC detection; instantiated CH_NUM times in a generate loop.
- The top handles the byte-pointer flip-flop, read mux, active-channel mux and tc registering.

Test Plan:
- Reset, then write 8'h34, 8'h12 to prog_addr=0 → ch0 base/cur addr = 16'h1234, ff_state back at 0; read prog_addr=0 twice → prog_dout 8'h34 then 8'h12.
- ch1 wc=16'h0002, addr=16'h0100, increment, no autoinit; 3 steps → addr 16'h0103, wc 16'hFFFF, tc=1 with tc_ch=1 only on the edge after the 3rd step.
- ch2 decrement, addr=16'h0000, wc=16'h0005; 1 step → addr 16'hFFFF, wc 16'h0004.
- ch3 autoinit, base addr 16'h4000, wc 16'h0001; 2 steps → tc pulses once, cur addr 16'h4000, cur wc 16'h0001 restored.
- Write low byte only (ff=1), pulse clear_ff, write 8'hAA to prog_addr=3 → ch1 wc low byte = 8'hAA, ff_state=1; prog_we to ch0 in the same cycle as a step on ch0 → write value kept, no tc.
- With DMA_TC_STATUS_EN: tc on ch1 → tc_status=4'b0010; status_rd → 4'b0000 next cycle; tc on ch0 in the same cycle as status_rd → 4'b0001.
